// File: rtl/segment_queue.sv
// Byte-stream to motion-segment word assembler feeding a small FIFO.
// Bytes pack LSB-first; a completed word is pushed on the edge that accepts its last byte.
module segment_queue #(
    parameter int unsigned READ_BYTES = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [7:0]                    in_byte,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          data_available,
    input  logic                          data_request,
    output logic [8*READ_BYTES-1:0]       data,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          underflow
);

    localparam int unsigned W     = 8 * READ_BYTES;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned BC_W  = (READ_BYTES > 1) ? $clog2(READ_BYTES) : 1;
    localparam logic [BC_W-1:0] LAST_BYTE  = BC_W'(READ_BYTES - 1);
    localparam logic [PTR_W:0]  FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fill_q, fill_d;
    logic             underflow_q, underflow_d;
    logic [W-1:0]     asm_q;
    logic [W-1:0]     mem_q [FIFO_DEPTH];

    logic             last_byte, full, accept, push, pop;
    logic [W-1:0]     push_word;

    always_comb begin
        last_byte = (byte_cnt_q == LAST_BYTE);
        full      = (fill_q == FULL_LEVEL);
        // Only a word-completing byte needs a free slot, so partial bytes flow while full.
        in_ready  = !(full && last_byte) && !flush;
        accept    = in_valid && in_ready;
        push      = accept && last_byte;
        pop       = data_request && (fill_q != '0);

        push_word = asm_q;
        push_word[8*byte_cnt_q +: 8] = in_byte;

        byte_cnt_d  = byte_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        underflow_d = underflow_q;

        if (flush) begin
            byte_cnt_d  = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fill_d      = '0;
            underflow_d = 1'b0;
        end else begin
            if (accept)
                byte_cnt_d = last_byte ? '0 : byte_cnt_q + BC_W'(1);
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                fill_d = fill_q + (PTR_W + 1)'(1);
            else if (pop && !push)
                fill_d = fill_q - (PTR_W + 1)'(1);
            if (data_request && (fill_q == '0))
                underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            underflow_q <= underflow_d;
        end
    end

    // Datapath storage is never reset; fill level alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < READ_BYTES; i++) begin
            if (accept && (byte_cnt_q == BC_W'(i)))
                asm_q[8*i +: 8] <= in_byte;
        end
        if (push)
            mem_q[wr_ptr_q] <= push_word;
    end

    assign data           = mem_q[rd_ptr_q];
    assign data_available = (fill_q != '0);
    assign fill_level     = fill_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_segment_queue.sv
// Scoreboard bench for segment_queue (READ_BYTES=4, FIFO_DEPTH=4).
`timescale 1ns/1ps
module tb_segment_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  in_byte = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        data_available;
    logic        data_request;
    logic        stim_req = 1'b0;
    logic        mon_req = 1'b0;
    logic        consume_en = 1'b0;
    logic [31:0] data;
    logic [2:0]  fill_level;
    logic        underflow;

    int          checks = 0;
    int          errors = 0;
    int          popped = 0;
    logic [31:0] exp_q[$];

    assign data_request = stim_req | mon_req;

    segment_queue #(.READ_BYTES(4), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_byte        (in_byte),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_available (data_available),
        .data_request   (data_request),
        .data           (data),
        .fill_level     (fill_level),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned waited = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h in_ready got 0 expected 1", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8]);
    endtask

    task automatic drain();
        int unsigned waited = 0;
        consume_en = 1'b1;
        do begin
            @(posedge clk);
            #2;
            waited++;
        end while (!(exp_q.size() == 0 && fill_level == 0) && waited < 60);
        if (!(exp_q.size() == 0 && fill_level == 0)) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: fill %0d queue %0d expected 0 0", fill_level, exp_q.size());
        end
        consume_en = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pop_base;
        logic [31:0] w;

        // Scoreboard monitor: sample head while available, pop it on the following edge.
        fork
            forever begin
                @(negedge clk);
                if (consume_en && data_available) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got %h expected no word", data);
                        mon_req = 1'b0;
                    end else begin
                        check("sb_word", data, exp_q.pop_front());
                        popped++;
                        mon_req = 1'b1;
                    end
                end else begin
                    mon_req = 1'b0;
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_fill", fill_level, 0);
        check("rst_avail", data_available, 0);
        check("rst_ready", in_ready, 1);
        check("rst_underflow", underflow, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, LSB-first assembly and one-cycle visibility
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("w1_avail_early", data_available, 0);
        send_byte(8'h44);
        check("w1_avail", data_available, 1);
        check("w1_data", data, 32'h44332211);
        check("w1_fill", fill_level, 1);
        exp_q.push_back(32'h44332211);
        drain();

        // Fill to full, partial bytes while full, blocked last byte until a pop
        for (int b = 1; b <= 16; b++)
            send_byte(8'(b));
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        exp_q.push_back(32'h100F0E0D);
        check("full_fill", fill_level, 4);
        check("full_ready_partial", in_ready, 1);
        for (int b = 17; b <= 19; b++) begin
            check("full_partial_ready", in_ready, 1);
            send_byte(8'(b));
        end
        check("full_fill_after_partial", fill_level, 4);
        check("full_ready_low", in_ready, 0);
        in_byte  = 8'd20;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("full_blocked_ready", in_ready, 0);
        check("full_blocked_fill", fill_level, 4);
        check("full_head", data, 32'h04030201);
        stim_req = 1'b1;
        @(posedge clk);
        #1;
        stim_req = 1'b0;
        void'(exp_q.pop_front());
        check("full_after_pop_fill", fill_level, 3);
        check("full_after_pop_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("full_refill", fill_level, 4);
        exp_q.push_back(32'h14131211);
        drain();

        // Simultaneous last-byte push and pop at fill_level 1
        send_word(32'hA1B2C3D4);
        check("pp_fill_pre", fill_level, 1);
        check("pp_head_pre", data, 32'hA1B2C3D4);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        in_byte  = 8'h88;
        in_valid = 1'b1;
        stim_req = 1'b1;
        @(negedge clk);
        check("pp_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stim_req = 1'b0;
        check("pp_fill", fill_level, 1);
        check("pp_data", data, 32'h88776655);
        exp_q.push_back(32'h88776655);
        drain();

        // Underflow: sticky, pointers untouched, cleared by flush
        stim_req = 1'b1;
        @(posedge clk);
        #1;
        stim_req = 1'b0;
        check("uf_set", underflow, 1);
        check("uf_fill", fill_level, 0);
        check("uf_avail", data_available, 0);
        repeat (3) @(posedge clk);
        #1;
        check("uf_sticky", underflow, 1);
        send_word(32'h0BADBEEF);
        check("uf_ptr_head", data, 32'h0BADBEEF);
        exp_q.push_back(32'h0BADBEEF);
        drain();
        check("uf_sticky2", underflow, 1);
        send_byte(8'h99);
        send_byte(8'h98);
        flush    = 1'b1;
        in_byte  = 8'h77;
        in_valid = 1'b1;
        stim_req = 1'b1;
        @(negedge clk);
        check("flush_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        stim_req = 1'b0;
        check("flush_underflow", underflow, 0);
        check("flush_fill", fill_level, 0);
        send_word(32'h13572468);
        check("flush_realign", data, 32'h13572468);
        exp_q.push_back(32'h13572468);
        drain();

        // Asynchronous reset mid-word with a stored word
        send_word(32'hCAFEF00D);
        check("ar_fill_pre", fill_level, 1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_fill", fill_level, 0);
        check("ar_avail", data_available, 0);
        check("ar_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(32'h04030201);
        check("ar_word", data, 32'h04030201);
        check("ar_fill_post", fill_level, 1);
        exp_q.push_back(32'h04030201);
        drain();

        // Ten words streamed back-to-back with a live consumer (pointer wrap)
        pop_base   = popped;
        consume_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++)
                w[8*i +: 8] = 8'(8'h40 + 4*k + i);
            exp_q.push_back(w);
            send_word(w);
        end
        drain();
        check("stream_count", popped - pop_base, 10);
        check("stream_fill", fill_level, 0);
        check("stream_underflow", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
